// File: rtl/multiport_regfile_pkg.sv
// Shared defaults for the integer register file and its read-port slices.
// Decode and writeback also take their sizing from here.
package multiport_regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/multiport_regfile_rf_read_port.sv
// One combinational read port: returns the register value and its readiness.
// A same-cycle write to the register is forwarded to the output (bypass).
module rf_read_port
  import multiport_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic [AW-1:0]   ra_i,
  input  logic [XLEN-1:0] regVal_i,
  input  logic            busy_i,
  input  logic            we0_i,
  input  logic [AW-1:0]   wa0_i,
  input  logic [XLEN-1:0] wd0_i,
  input  logic            we1_i,
  input  logic [AW-1:0]   wa1_i,
  input  logic [XLEN-1:0] wd1_i,
  output logic [XLEN-1:0] rd_o,
  output logic            rrdy_o
);

  logic isZero;
  logic hit0;
  logic hit1;

  // Port 1 is the load writeback and outranks port 0 when both target this register.
  always_comb begin
    isZero = (ra_i == AW'(ZERO_REG));
    hit1   = we1_i && (wa1_i == ra_i);
    hit0   = we0_i && (wa0_i == ra_i);
    rd_o   = regVal_i;
    rrdy_o = !busy_i;
    if (isZero) begin
      rd_o   = '0;
      rrdy_o = 1'b1;
    end else if (hit1) begin
      rd_o   = wd1_i;
      rrdy_o = 1'b1;
    end else if (hit0) begin
      rd_o   = wd0_i;
      rrdy_o = 1'b1;
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// Integer register file for the pipelined core. It has NR bypassed read ports and
// two write ports, and a busy scoreboard for in-flight destinations.
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int NR   = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NR*AW-1:0]   RA,
  output logic [NR*XLEN-1:0] RD,
  output logic [NR-1:0]      RRDY,
  input  logic               WE0,
  input  logic [AW-1:0]      WA0,
  input  logic [XLEN-1:0]    WD0,
  input  logic               WE1,
  input  logic [AW-1:0]      WA1,
  input  logic [XLEN-1:0]    WD1,
  input  logic               ISS_EN,
  input  logic [AW-1:0]      ISS_A,
  output logic [NREG-1:0]    BUSY
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Port 1 is applied last, so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (WE0 && (WA0 != AW'(ZERO_REG))) regs_d[WA0] = WD0;
    if (WE1 && (WA1 != AW'(ZERO_REG))) regs_d[WA1] = WD1;
    regs_d[ZERO_REG] = '0;
  end

  // A new issue keeps a register busy even if an older producer retires in the same cycle.
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_d[r] = (ISS_EN && (ISS_A == AW'(r))) ||
                  (busy_q[r] && !((WE0 && (WA0 == AW'(r))) || (WE1 && (WA1 == AW'(r)))));
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign BUSY = busy_q;

  for (genvar gi = 0; gi < NR; gi++) begin : gReadPort
    logic [AW-1:0] ra;
    assign ra = RA[gi*AW +: AW];

    rf_read_port #(
      .XLEN(XLEN),
      .AW  (AW)
    ) uPort (
      .ra_i    (ra),
      .regVal_i(regs_q[ra]),
      .busy_i  (busy_q[ra]),
      .we0_i   (WE0),
      .wa0_i   (WA0),
      .wd0_i   (WD0),
      .we1_i   (WE1),
      .wa1_i   (WA1),
      .wd1_i   (WD1),
      .rd_o    (RD[gi*XLEN +: XLEN]),
      .rrdy_o  (RRDY[gi])
    );
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench: a table of directed vectors on the default configuration, plus
// hand-written sequences on a 64-bit / 16-register / 3-port instance and for reset.
module tb_multiport_regfile;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        issEn;
    logic [4:0]  issA;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] expRd0;
    logic [31:0] expRd1;
    logic [1:0]  expRrdy;
    logic [31:0] expBusy;
  } vec_t;

  logic CLK;
  logic RESET_N;

  logic [9:0]  aRA;
  logic [63:0] aRD;
  logic [1:0]  aRRDY;
  logic        aWE0, aWE1, aIssEn;
  logic [4:0]  aWA0, aWA1, aIssA;
  logic [31:0] aWD0, aWD1;
  logic [31:0] aBUSY;

  logic [11:0]  bRA;
  logic [191:0] bRD;
  logic [2:0]   bRRDY;
  logic         bWE0, bWE1, bIssEn;
  logic [3:0]   bWA0, bWA1, bIssA;
  logic [63:0]  bWD0, bWD1;
  logic [15:0]  bBUSY;

  int nChecks = 0;
  int nPass   = 0;
  vec_t vecs[$];

  multiport_regfile dutA (
    .CLK(CLK), .RESET_N(RESET_N), .RA(aRA), .RD(aRD), .RRDY(aRRDY),
    .WE0(aWE0), .WA0(aWA0), .WD0(aWD0), .WE1(aWE1), .WA1(aWA1), .WD1(aWD1),
    .ISS_EN(aIssEn), .ISS_A(aIssA), .BUSY(aBUSY)
  );

  multiport_regfile #(.XLEN(64), .NREG(16), .AW(4), .NR(3)) dutB (
    .CLK(CLK), .RESET_N(RESET_N), .RA(bRA), .RD(bRD), .RRDY(bRRDY),
    .WE0(bWE0), .WA0(bWA0), .WD0(bWD0), .WE1(bWE1), .WA1(bWA1), .WD1(bWD1),
    .ISS_EN(bIssEn), .ISS_A(bIssA), .BUSY(bBUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mkVec(
    input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
    input logic issEn, input logic [4:0] issA,
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [31:0] expRd0, input logic [31:0] expRd1,
    input logic [1:0] expRrdy, input logic [31:0] expBusy);
    vec_t v;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.issEn = issEn; v.issA = issA;
    v.ra0 = ra0; v.ra1 = ra1;
    v.expRd0 = expRd0; v.expRd1 = expRd1;
    v.expRrdy = expRrdy; v.expBusy = expBusy;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    aWE0 = v.we0; aWA0 = v.wa0; aWD0 = v.wd0;
    aWE1 = v.we1; aWA1 = v.wa1; aWD1 = v.wd1;
    aIssEn = v.issEn; aIssA = v.issA;
    aRA = {v.ra1, v.ra0};
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    RESET_N = 1'b0;
    aWE0 = 1'b0; aWA0 = '0; aWD0 = '0; aWE1 = 1'b0; aWA1 = '0; aWD1 = '0;
    aIssEn = 1'b0; aIssA = '0; aRA = '0;
    bWE0 = 1'b0; bWA0 = '0; bWD0 = '0; bWE1 = 1'b0; bWA1 = '0; bWD1 = '0;
    bIssEn = 1'b0; bIssA = '0; bRA = '0;

    //                we0   wa0    wd0            we1   wa1    wd1        iss   issA   ra0    ra1    expRd0         expRd1         rrdy   busy
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd5, 32'h0,         32'h0,         2'b11, 32'h0));
    vecs.push_back(mkVec(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF,  32'h0,         2'b11, 32'h0));
    vecs.push_back(mkVec(1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF,  32'h0,         2'b11, 32'h0));
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd5, 32'h0,         32'hDEADBEEF,  2'b11, 32'h0));
    vecs.push_back(mkVec(1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22,        32'h22,        2'b11, 32'h0));
    vecs.push_back(mkVec(1'b1, 5'd3, 32'hA,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd3, 32'h22,        32'hA,         2'b11, 32'h0));
    vecs.push_back(mkVec(1'b1, 5'd3, 32'hB,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd3, 32'hB,         32'hB,         2'b11, 32'h0));
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd3, 5'd9, 32'hB,         32'h0,         2'b11, 32'h0));
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd3, 32'h0,         32'hB,         2'b10, 32'h200));
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd9, 32'h99,        32'h99,        2'b11, 32'h200));
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd0, 32'h99,        32'h0,         2'b11, 32'h0));
    vecs.push_back(mkVec(1'b1, 5'd9, 32'h55,       1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd0, 32'h55,        32'h0,         2'b11, 32'h0));
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd0, 32'h55,        32'h0,         2'b10, 32'h200));
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd0, 32'h55,        32'h0,         2'b10, 32'h200));
    vecs.push_back(mkVec(1'b1, 5'd9, 32'h66,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd0, 32'h66,        32'h0,         2'b11, 32'h200));
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd0, 32'h66,        32'h0,         2'b11, 32'h0));
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         2'b11, 32'h0));
    vecs.push_back(mkVec(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd9, 32'h0,         32'h66,        2'b11, 32'h0));

    #11;
    checkOutput("reset a rd",   {32'h0, aRD[63:32] | aRD[31:0]}, 64'h0);
    checkOutput("reset a rrdy", {62'h0, aRRDY}, 64'h3);
    checkOutput("reset a busy", {32'h0, aBUSY}, 64'h0);
    checkOutput("reset b rd",   bRD[63:0] | bRD[127:64] | bRD[191:128], 64'h0);
    checkOutput("reset b rrdy", {61'h0, bRRDY}, 64'h7);
    #1 RESET_N = 1'b1;

    foreach (vecs[i]) begin
      @(negedge CLK);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d rd0", i),  {32'h0, aRD[31:0]},  {32'h0, vecs[i].expRd0});
      checkOutput($sformatf("v%0d rd1", i),  {32'h0, aRD[63:32]}, {32'h0, vecs[i].expRd1});
      checkOutput($sformatf("v%0d rrdy", i), {62'h0, aRRDY},      {62'h0, vecs[i].expRrdy});
      checkOutput($sformatf("v%0d busy", i), {32'h0, aBUSY},      {32'h0, vecs[i].expBusy});
    end
    @(negedge CLK);
    aWE0 = 1'b0; aWE1 = 1'b0; aIssEn = 1'b0;

    bWE0 = 1'b1; bWA0 = 4'd5; bWD0 = 64'hDEADBEEF_CAFEF00D; bRA = {4'd0, 4'd15, 4'd5};
    #1;
    checkOutput("b bypass wr5 p0", bRD[63:0], 64'hDEADBEEF_CAFEF00D);
    checkOutput("b reg15 p1", bRD[127:64], 64'h0);
    @(negedge CLK);
    bWA0 = 4'd0; bWD0 = 64'h1234; bRA = {4'd0, 4'd5, 4'd0};
    #1;
    checkOutput("b zero p0", bRD[63:0], 64'h0);
    checkOutput("b reg5 p1", bRD[127:64], 64'hDEADBEEF_CAFEF00D);
    checkOutput("b rrdy", {61'h0, bRRDY}, 64'h7);
    @(negedge CLK);
    bWA0 = 4'd7; bWD0 = 64'h11; bWE1 = 1'b1; bWA1 = 4'd7; bWD1 = 64'h22; bRA = {4'd7, 4'd0, 4'd0};
    #1;
    checkOutput("b collide p2", bRD[191:128], 64'h22);
    checkOutput("b zero after wr0", bRD[63:0], 64'h0);
    @(negedge CLK);
    bWE1 = 1'b0; bWA0 = 4'd3; bWD0 = 64'hA; bRA = {4'd0, 4'd0, 4'd7};
    #1;
    checkOutput("b reg7 stored", bRD[63:0], 64'h22);
    @(negedge CLK);
    bWD0 = 64'hB; bRA = {4'd0, 4'd3, 4'd0};
    #1;
    checkOutput("b bypass reg3 p1", bRD[127:64], 64'hB);
    checkOutput("b bypass rrdy", {61'h0, bRRDY}, 64'h7);
    @(negedge CLK);
    bWE0 = 1'b0; bIssEn = 1'b1; bIssA = 4'd15; bRA = {4'd0, 4'd3, 4'd15};
    #1;
    checkOutput("b reg3 stored", bRD[127:64], 64'hB);
    checkOutput("b busy pre", {48'h0, bBUSY}, 64'h0);
    @(negedge CLK);
    bIssEn = 1'b0;
    #1;
    checkOutput("b busy15", {48'h0, bBUSY}, 64'h8000);
    checkOutput("b rrdy busy15", {61'h0, bRRDY}, 64'h6);

    // Mid-cycle asynchronous reset, then a write/issue lost while reset is held.
    aWE0 = 1'b1; aWA0 = 5'd12; aWD0 = 32'h12345; aIssEn = 1'b1; aIssA = 5'd12;
    @(negedge CLK);
    aWE0 = 1'b0; aIssEn = 1'b0; aRA = {5'd7, 5'd12};
    #1;
    checkOutput("pre-reset a busy", {32'h0, aBUSY}, 64'h1000);
    checkOutput("pre-reset a rd0", {32'h0, aRD[31:0]}, 64'h12345);
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    bRA = {4'd7, 4'd3, 4'd5};
    #1;
    checkOutput("async reset a rd",   aRD, 64'h0);
    checkOutput("async reset a rrdy", {62'h0, aRRDY}, 64'h3);
    checkOutput("async reset a busy", {32'h0, aBUSY}, 64'h0);
    checkOutput("async reset b rd",   bRD[63:0] | bRD[127:64] | bRD[191:128], 64'h0);
    checkOutput("async reset b rrdy", {61'h0, bRRDY}, 64'h7);
    checkOutput("async reset b busy", {48'h0, bBUSY}, 64'h0);
    aWE0 = 1'b1; aWA0 = 5'd4; aWD0 = 32'h77; aIssEn = 1'b1; aIssA = 5'd4;
    @(posedge CLK);
    #2;
    RESET_N = 1'b1;
    aWE0 = 1'b0; aIssEn = 1'b0; aRA = {5'd0, 5'd4};
    #1;
    checkOutput("lost write reg4", {32'h0, aRD[31:0]}, 64'h0);
    checkOutput("lost issue busy", {32'h0, aBUSY}, 64'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
